// File: rtl/req_ack_arb_pkg.sv
// Shared state encoding and sizing helper for the req/ack round-robin arbiter.
package req_ack_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_ISSUE = 2'd1;
  localparam state_t S_WAIT  = 2'd2;
  localparam state_t S_ACK   = 2'd3;

  // Width of a requester index; never below one bit.
  function automatic int grant_w(input int n);
    return (n < 3) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/req_ack_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request after last_grant, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int GW      = 2
) (
  input  logic [NUM_REQ-1:0] req_masked,
  input  logic [GW-1:0]      last_grant,
  output logic               valid,
  output logic [GW-1:0]      winner
);

  logic [GW-1:0]      cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0] hit;

  // Candidate gi is the requester (last_grant + gi + 1) mod NUM_REQ.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    logic [GW:0] sum;
    assign sum          = {1'b0, last_grant} + (GW+1)'(gi + 1);
    assign cand_idx[gi] = GW'((sum >= (GW+1)'(NUM_REQ)) ? sum - (GW+1)'(NUM_REQ) : sum);
    assign hit[gi]      = req_masked[cand_idx[gi]];
  end

  always_comb begin
    valid  = 1'b0;
    winner = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (hit[i]) begin
        valid  = 1'b1;
        winner = cand_idx[i];
      end
    end
  end

endmodule

// File: rtl/req_ack_arbiter.sv
// Round-robin arbiter sharing one downstream command engine between NUM_REQ
// four-phase req/ack requesters.
module req_ack_arbiter
  import req_ack_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CMD_W   = 64,
  localparam int GW     = grant_w(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NUM_REQ-1:0]       req,
  input  logic                     req_en,
  input  logic [NUM_REQ*CMD_W-1:0] cmd_in,
  output logic [NUM_REQ-1:0]       ack,
  output logic [NUM_REQ-1:0]       ack_pulse,
  output logic                     dn_valid,
  input  logic                     dn_ready,
  output logic [CMD_W-1:0]         dn_cmd,
  input  logic                     dn_done,
  output logic [GW-1:0]            grant_id,
  output logic                     busy,
  output logic                     abort
);

  state_t             state_reg;
  logic [NUM_REQ-1:0] ack_reg;
  logic               ack_first_reg;
  logic               dn_valid_reg;
  logic [CMD_W-1:0]   dn_cmd_reg;
  logic [GW-1:0]      grant_id_reg;
  logic [GW-1:0]      last_grant_reg;
  logic               busy_reg;
  logic               abort_reg;

  logic [CMD_W-1:0]   cmd_arr [NUM_REQ];
  logic               pick_valid;
  logic [GW-1:0]      pick_id;
  logic               req_held;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cmd
    assign cmd_arr[gi] = cmd_in[gi*CMD_W +: CMD_W];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .GW      (GW)
  ) u_pick (
    .req_masked (req & ~ack_reg),
    .last_grant (last_grant_reg),
    .valid      (pick_valid),
    .winner     (pick_id)
  );

  assign req_held = req[grant_id_reg];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg      <= S_IDLE;
      ack_reg        <= '0;
      ack_first_reg  <= 1'b0;
      dn_valid_reg   <= 1'b0;
      dn_cmd_reg     <= '0;
      grant_id_reg   <= '0;
      last_grant_reg <= GW'(NUM_REQ - 1);
      busy_reg       <= 1'b0;
      abort_reg      <= 1'b0;
    end else begin
      abort_reg     <= 1'b0;
      ack_first_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (req_en && pick_valid) begin
            grant_id_reg   <= pick_id;
            last_grant_reg <= pick_id;
            dn_cmd_reg     <= cmd_arr[pick_id];
            dn_valid_reg   <= 1'b1;
            busy_reg       <= 1'b1;
            state_reg      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (dn_ready) begin
            dn_valid_reg <= 1'b0;
            state_reg    <= S_WAIT;
          end
        end
        S_WAIT: begin
          // The transfer always runs to completion; a vanished requester only loses its ack.
          if (dn_done) begin
            if (req_held) begin
              ack_reg       <= {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id_reg;
              ack_first_reg <= 1'b1;
              state_reg     <= S_ACK;
            end else begin
              abort_reg <= 1'b1;
              busy_reg  <= 1'b0;
              state_reg <= S_IDLE;
            end
          end
        end
        S_ACK: begin
          if (!req_held) begin
            ack_reg   <= '0;
            busy_reg  <= 1'b0;
            state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign ack       = ack_reg;
  assign ack_pulse = ack_first_reg ? ack_reg : '0;
  assign dn_valid  = dn_valid_reg;
  assign dn_cmd    = dn_cmd_reg;
  assign grant_id  = grant_id_reg;
  assign busy      = busy_reg;
  assign abort     = abort_reg;

endmodule

// File: tb/tb_req_ack_arbiter.sv
// Directed bench for req_ack_arbiter: inputs change and outputs are checked on the falling edge.
module tb_req_ack_arbiter;

  localparam int NUM_REQ = 4;
  localparam int CMD_W   = 64;
  localparam logic [63:0] CMD0 = 64'h1000_0000_0000_00A0;
  localparam logic [63:0] CMD1 = 64'h0000_0000_0000_00A5;
  localparam logic [63:0] CMD2 = 64'h0000_0000_0000_00C2;
  localparam logic [63:0] CMD3 = 64'h0000_0000_0000_00D3;

  logic                     clk = 1'b0;
  logic                     rstn = 1'b0;
  logic [NUM_REQ-1:0]       req = '0;
  logic                     req_en = 1'b0;
  logic [NUM_REQ*CMD_W-1:0] cmd_in = '0;
  logic [NUM_REQ-1:0]       ack;
  logic [NUM_REQ-1:0]       ack_pulse;
  logic                     dn_valid;
  logic                     dn_ready = 1'b0;
  logic [CMD_W-1:0]         dn_cmd;
  logic                     dn_done = 1'b0;
  logic [1:0]               grant_id;
  logic                     busy;
  logic                     abort;

  int vectors = 0;
  int fails   = 0;
  logic [63:0] cmds [4];

  always #5 clk = ~clk;

  req_ack_arbiter #(
    .NUM_REQ (NUM_REQ),
    .CMD_W   (CMD_W)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req       (req),
    .req_en    (req_en),
    .cmd_in    (cmd_in),
    .ack       (ack),
    .ack_pulse (ack_pulse),
    .dn_valid  (dn_valid),
    .dn_ready  (dn_ready),
    .dn_cmd    (dn_cmd),
    .dn_done   (dn_done),
    .grant_id  (grant_id),
    .busy      (busy),
    .abort     (abort)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic done_pulse();
    dn_done = 1'b1;
    @(negedge clk);
    dn_done = 1'b0;
  endtask

  initial begin
    int g;
    cmds[0] = CMD0;
    cmds[1] = CMD1;
    cmds[2] = CMD2;
    cmds[3] = CMD3;
    cmd_in = {CMD3, CMD2, CMD1, CMD0};

    // Reset values
    repeat (2) nxt();
    check("rst_ack", 64'(ack), 64'h0);
    check("rst_ack_pulse", 64'(ack_pulse), 64'h0);
    check("rst_dn_valid", 64'(dn_valid), 64'h0);
    check("rst_dn_cmd", dn_cmd, 64'h0);
    check("rst_grant_id", 64'(grant_id), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_abort", 64'(abort), 64'h0);
    rstn = 1'b1;
    nxt();
    check("idle_busy", 64'(busy), 64'h0);

    // Contention: all four requesting, order 0,1,2,3,0
    req_en   = 1'b1;
    dn_ready = 1'b1;
    req      = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      g = k % 4;
      nxt();
      check("cont_grant", 64'(grant_id), 64'(g));
      check("cont_valid", 64'(dn_valid), 64'h1);
      check("cont_cmd", dn_cmd, cmds[g]);
      nxt();
      check("cont_wait_valid", 64'(dn_valid), 64'h0);
      done_pulse();
      check("cont_ack", 64'(ack), 64'(4'b0001 << g));
      check("cont_ack_pulse", 64'(ack_pulse), 64'(4'b0001 << g));
      if (k == 4) req = 4'b0000;
      else req[g] = 1'b0;
      nxt();
      check("cont_ack_drop", 64'(ack), 64'h0);
      check("cont_idle", 64'(busy), 64'h0);
      if (k < 4) req[g] = 1'b1;
    end

    // Single request from requester 1
    req = 4'b0010;
    nxt();
    check("single_valid", 64'(dn_valid), 64'h1);
    check("single_cmd", dn_cmd, CMD1);
    check("single_grant", 64'(grant_id), 64'h1);
    check("single_busy", 64'(busy), 64'h1);
    nxt();
    check("single_accept", 64'(dn_valid), 64'h0);
    nxt();
    nxt();
    check("single_no_ack_yet", 64'(ack), 64'h0);
    done_pulse();
    check("single_ack", 64'(ack), 64'h2);
    check("single_pulse", 64'(ack_pulse), 64'h2);
    nxt();
    check("single_ack_hold", 64'(ack), 64'h2);
    check("single_pulse_once", 64'(ack_pulse), 64'h0);
    req = 4'b0000;
    nxt();
    check("single_ack_fall", 64'(ack), 64'h0);
    check("single_idle", 64'(busy), 64'h0);

    // Backpressure on requester 3, with a stray dn_done during ISSUE
    dn_ready = 1'b0;
    req      = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      nxt();
      check("bp_valid", 64'(dn_valid), 64'h1);
      check("bp_cmd", dn_cmd, CMD3);
      check("bp_grant", 64'(grant_id), 64'h3);
      dn_done = (i == 1);
    end
    dn_done  = 1'b0;
    dn_ready = 1'b1;
    nxt();
    check("bp_accept", 64'(dn_valid), 64'h0);
    check("bp_busy", 64'(busy), 64'h1);
    check("bp_no_ack", 64'(ack), 64'h0);
    nxt();
    check("bp_stray_done_ignored", 64'(ack), 64'h0);
    check("bp_still_busy", 64'(busy), 64'h1);
    done_pulse();
    check("bp_ack", 64'(ack), 64'h8);
    check("bp_pulse", 64'(ack_pulse), 64'h8);
    req = 4'b0000;
    nxt();
    check("bp_ack_fall", 64'(ack), 64'h0);

    // Abort: requester 2 drops req during WAIT
    req = 4'b0100;
    nxt();
    check("abort_grant", 64'(grant_id), 64'h2);
    check("abort_valid", 64'(dn_valid), 64'h1);
    nxt();
    check("abort_in_wait", 64'(dn_valid), 64'h0);
    req = 4'b0000;
    nxt();
    check("abort_not_yet", 64'(abort), 64'h0);
    done_pulse();
    check("abort_pulse", 64'(abort), 64'h1);
    check("abort_no_ack", 64'(ack), 64'h0);
    check("abort_idle", 64'(busy), 64'h0);
    nxt();
    check("abort_once", 64'(abort), 64'h0);
    check("abort_no_ack_later", 64'(ack), 64'h0);

    // req_en gating
    req_en = 1'b0;
    req    = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      nxt();
      check("gate_no_valid", 64'(dn_valid), 64'h0);
      check("gate_no_busy", 64'(busy), 64'h0);
    end
    req_en = 1'b1;
    nxt();
    check("gate_valid", 64'(dn_valid), 64'h1);
    check("gate_grant", 64'(grant_id), 64'h2);
    nxt();
    req_en = 1'b0;
    nxt();
    check("gate_wait_busy", 64'(busy), 64'h1);
    done_pulse();
    check("gate_ack", 64'(ack), 64'h4);
    req = 4'b0000;
    nxt();
    check("gate_ack_fall", 64'(ack), 64'h0);
    req_en = 1'b1;

    // Asynchronous reset during WAIT
    req = 4'b0010;
    nxt();
    check("rstmid_grant", 64'(grant_id), 64'h1);
    nxt();
    check("rstmid_busy", 64'(busy), 64'h1);
    #2 rstn = 1'b0;
    #1;
    check("rstmid_busy0", 64'(busy), 64'h0);
    check("rstmid_grant0", 64'(grant_id), 64'h0);
    check("rstmid_cmd0", dn_cmd, 64'h0);
    check("rstmid_valid0", 64'(dn_valid), 64'h0);
    check("rstmid_ack0", 64'(ack), 64'h0);
    req = 4'b1111;
    nxt();
    rstn = 1'b1;
    nxt();
    check("rstmid_prio_grant", 64'(grant_id), 64'h0);
    check("rstmid_prio_cmd", dn_cmd, CMD0);
    check("rstmid_prio_valid", 64'(dn_valid), 64'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/req_ack_arbiter.md
# req_ack_arbiter

Round-robin arbiter that shares one downstream command engine (AXI burst master front-end) between NUM_REQ requesters, each using a level-sensitive four-phase req/ack handshake. It latches the winning requester's command, issues it downstream with a valid/ready handshake, and waits for completion. It then acknowledges that requester and holds ack until req is released. It sits between CPU-side or slow register interfaces, which may miss cycles, and the single burst engine.

## Interface
- NUM_REQ, 4: number of requesters; legal range 2..16.
- CMD_W, 64: width of one requester's command word (address, length, direction packed by the requester).
- clk  in  1  clock; all logic is on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester level request; the command must be stable while req is high.
- req_en  in  1  global enable; new grants are made only while high.
- cmd_in  in  NUM_REQ*CMD_W  flattened commands; requester i occupies bits [i*CMD_W +: CMD_W].
- ack  out  NUM_REQ  per-requester level acknowledge.
- ack_pulse  out  NUM_REQ  one-cycle pulse on the cycle ack[i] rises.
- dn_valid  out  1  downstream command valid.
- dn_ready  in  1  downstream accepts the command when dn_valid & dn_ready.
- dn_cmd  out  CMD_W  latched command of the granted requester.
- dn_done  in  1  one-cycle pulse when the downstream transaction completes.
- grant_id  out  $clog2(NUM_REQ)  index of the current or last granted requester.
- busy  out  1  high in every state except IDLE.
- abort  out  1  one-cycle pulse when a transaction completes after its requester has already dropped req.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, ACK.
- IDLE: if req_en and any req[i] is high and ack[i] is low, the round-robin pick selects a winner. The winner's index goes into grant_id and its cmd_in slice into dn_cmd, and the FSM moves to ISSUE.
- Round-robin: search starts at last_grant+1 and wraps modulo NUM_REQ. The pointer updates only on a grant. After reset last_grant=NUM_REQ-1, so requester 0 has first priority.
- ISSUE: dn_valid=1. dn_cmd and grant_id stay stable until dn_valid & dn_ready, then the FSM moves to WAIT. dn_done is ignored while in ISSUE.
- WAIT: on dn_done, if req[grant_id] is still high, the FSM moves to ACK. If req[grant_id] is already low, it pulses abort and returns to IDLE without asserting ack.
- ACK: ack[grant_id]=1. ack_pulse[grant_id]=1 on the first ACK cycle only. When req[grant_id]=0, the FSM moves to IDLE and ack drops.
- A req drop during ISSUE or WAIT does not cancel the downstream transaction; the transaction always runs to dn_done.
- req_en low does not stall ISSUE, WAIT or ACK. It only blocks new grants in IDLE.
- At most one ack bit is high at any time. ack_pulse is a subset of ack.
- Reset values: state=IDLE, ack=0, ack_pulse=0, dn_valid=0, dn_cmd=0, grant_id=0, busy=0, abort=0, last_grant=NUM_REQ-1. Reset asserted mid-transaction returns everything to these values immediately; the downstream engine is reset by the same rstn.

## Timing
- All outputs are registered except ack_pulse, which is decoded from the state and the ACK-entry flag.
- The winner is sampled at edge N in IDLE. dn_valid=1 in cycle N+1.
- With dn_ready already high, the command is accepted in cycle N+1 and the FSM is in WAIT in cycle N+2.
- dn_done at edge M gives ack=1 and ack_pulse=1 in cycle M+1.
- req low sampled at edge K gives ack=0 and IDLE in cycle K+1. The earliest next grant is sampled at edge K+1, so dn_valid is next high in cycle K+2.
- Minimum back-to-back turnaround is 4 cycles per transaction (IDLE, ISSUE, WAIT, ACK) plus the downstream latency.
- Simultaneous requests: exactly one grant per IDLE visit; the others wait for later IDLE visits.
- When dn_done and the req drop arrive in the same cycle, abort is taken (req is sampled low).

## Structure
- Package req_ack_arb_pkg holds the state enum (IDLE, ISSUE, WAIT, ACK) and a localparam function for the grant_id width.
- One sub-module, rr_pick. It is combinational: inputs are the request vector masked by ~ack and the last_grant pointer; outputs are a valid flag and the winner index.
- The FSM, the command latch and the pointer register live in req_ack_arbiter.

## Test plan
- Single request: req=4'b0010 with cmd 0xA5, dn_ready=1, dn_done 3 cycles after accept -> dn_cmd=0xA5, grant_id=1, ack[1] rises the cycle after dn_done with one ack_pulse, and ack falls the cycle after req[1] drops.
- Contention: req=4'b1111 held, each requester drops req after ack -> grant order 0,1,2,3,0 and never two ack bits high.
- Backpressure: dn_ready low for 5 cycles -> dn_valid held with dn_cmd/grant_id stable; one transfer on the first ready cycle; a dn_done injected during ISSUE is ignored.
- Abort: req[2] drops during WAIT -> on dn_done abort pulses once, ack[2] stays 0, and the FSM is back in IDLE the next cycle.
- req_en gating: req_en=0 with req=4'b0100 -> no grant. req_en=1 -> dn_valid the following cycle. req_en=0 during WAIT -> the transaction still completes and is acked.
- Reset mid-transaction: rstn low during WAIT -> all outputs take their reset values asynchronously; after release, requester 0 has priority.
